// File: rtl/onehot_decoder_pkg.sv
// Shared types and helpers for the registered one-hot decoder.
package onehot_decoder_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HOLD = 2'd1,
        SCAN = 2'd2
    } state_t;

    // Widest one-hot vector the helper can produce; NUM_OUT must not exceed it.
    localparam int unsigned ONEHOT_MAX = 64;

    // clog2 with a floor of 1 so single-value counters still get a bit.
    function automatic int unsigned cnt_width(input int unsigned n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

    function automatic int unsigned ptr_width(input int unsigned num_out);
        return cnt_width(num_out);
    endfunction

    function automatic int unsigned div_width(input int unsigned scan_div);
        return cnt_width(scan_div);
    endfunction

    // One-hot of addr; all-zero when addr is not below num_out.
    function automatic logic [ONEHOT_MAX-1:0] onehot(input logic [63:0] addr,
                                                     input int unsigned num_out);
        if (addr >= 64'(num_out)) begin
            return '0;
        end
        return ONEHOT_MAX'(1) << addr;
    endfunction

endpackage

// File: rtl/onehot_decoder_seq_scan_tick_div.sv
// Free-running divider producing a tick on the last cycle of each SCAN_DIV period.
module scan_tick_div
    import onehot_decoder_pkg::*;
#(
    parameter int unsigned SCAN_DIV = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic tick
);

    localparam int unsigned DIV_W = div_width(SCAN_DIV);

    logic [DIV_W-1:0] cnt_q, cnt_d;
    logic             last;

    assign last = (cnt_q == DIV_W'(SCAN_DIV - 1));
    assign tick = en && last;

    // Next count: clear wins, otherwise count 0..SCAN_DIV-1 while enabled.
    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (en) begin
            cnt_d = last ? '0 : cnt_q + DIV_W'(1);
        end
    end

    // Counter register with asynchronous clear.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/onehot_decoder_seq.sv
// Registered one-hot decoder: handshaked direct decode or autonomous strobe scan.
module onehot_decoder_seq
    import onehot_decoder_pkg::*;
#(
    parameter int unsigned ADDR_W   = 2,
    parameter int unsigned NUM_OUT  = 4,
    parameter int unsigned SCAN_DIV = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               mode,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [ADDR_W-1:0]  in_addr,
    input  logic               out_ready,
    output logic [NUM_OUT-1:0] y,
    output logic               y_valid,
    output logic               addr_err,
    output logic               scan_wrap
);

    localparam int unsigned PTR_W = ptr_width(NUM_OUT);

    state_t             state_q, state_d;
    logic [NUM_OUT-1:0] y_q, y_d;
    logic               y_valid_q, y_valid_d;
    logic               addr_err_q, addr_err_d;
    logic               scan_wrap_q, scan_wrap_d;
    logic [PTR_W-1:0]   ptr_q, ptr_d;
    logic [PTR_W-1:0]   ptr_adv;
    logic               ptr_wraps;
    logic               tick;
    logic               scanning;
    logic               accept;

    assign scanning = mode && (state_q == SCAN);
    assign in_ready = !mode && (state_q != SCAN) && (!y_valid_q || out_ready);
    assign accept   = in_valid && in_ready;

    // Divider is held clear outside an active scan so every entry starts at 0.
    scan_tick_div #(
        .SCAN_DIV(SCAN_DIV)
    ) u_div (
        .clk (clk),
        .rst (rst),
        .clr (!scanning),
        .en  (scanning),
        .tick(tick)
    );

    // Scan pointer step: advance on each divider tick, wrapping after NUM_OUT-1.
    always_comb begin
        ptr_adv   = ptr_q;
        ptr_wraps = 1'b0;
        if (tick) begin
            if (ptr_q == PTR_W'(NUM_OUT - 1)) begin
                ptr_adv   = '0;
                ptr_wraps = 1'b1;
            end else begin
                ptr_adv = ptr_q + PTR_W'(1);
            end
        end
    end

    // Next-state logic: mode has priority over the direct-decode handshake.
    always_comb begin
        state_d     = state_q;
        y_d         = y_q;
        y_valid_d   = y_valid_q;
        addr_err_d  = 1'b0;
        scan_wrap_d = 1'b0;
        ptr_d       = ptr_q;
        if (mode) begin
            if (state_q != SCAN) begin
                // Entering scan drops any pending HOLD output without handshake.
                state_d   = SCAN;
                ptr_d     = '0;
                y_d       = NUM_OUT'(1);
                y_valid_d = 1'b1;
            end else begin
                ptr_d       = ptr_adv;
                scan_wrap_d = ptr_wraps;
                y_d         = NUM_OUT'(onehot(64'(ptr_adv), NUM_OUT));
                y_valid_d   = 1'b1;
            end
        end else if (state_q == SCAN) begin
            state_d   = IDLE;
            ptr_d     = '0;
            y_d       = '0;
            y_valid_d = 1'b0;
        end else if (accept) begin
            state_d    = HOLD;
            y_d        = NUM_OUT'(onehot(64'(in_addr), NUM_OUT));
            y_valid_d  = 1'b1;
            addr_err_d = (64'(in_addr) >= 64'(NUM_OUT));
        end else if (y_valid_q && out_ready) begin
            state_d   = IDLE;
            y_d       = '0;
            y_valid_d = 1'b0;
        end
    end

    // State and output registers with asynchronous clear.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            y_q         <= '0;
            y_valid_q   <= 1'b0;
            addr_err_q  <= 1'b0;
            scan_wrap_q <= 1'b0;
            ptr_q       <= '0;
        end else begin
            state_q     <= state_d;
            y_q         <= y_d;
            y_valid_q   <= y_valid_d;
            addr_err_q  <= addr_err_d;
            scan_wrap_q <= scan_wrap_d;
            ptr_q       <= ptr_d;
        end
    end

    assign y         = y_q;
    assign y_valid   = y_valid_q;
    assign addr_err  = addr_err_q;
    assign scan_wrap = scan_wrap_q;

endmodule

// File: tb/tb_onehot_decoder_seq.sv
// Scoreboard bench for onehot_decoder_seq (ADDR_W=3, NUM_OUT=6, SCAN_DIV=3).
module tb_onehot_decoder_seq;

    localparam int unsigned ADDR_W   = 3;
    localparam int unsigned NUM_OUT  = 6;
    localparam int unsigned SCAN_DIV = 3;

    typedef struct packed {
        logic [NUM_OUT-1:0] y;
        logic               err;
        logic               wrap;
    } exp_t;

    logic               clk;
    logic               rst;
    logic               mode;
    logic               in_valid;
    logic               in_ready;
    logic [ADDR_W-1:0]  in_addr;
    logic               out_ready;
    logic [NUM_OUT-1:0] y;
    logic               y_valid;
    logic               addr_err;
    logic               scan_wrap;

    int   checks = 0;
    int   errors = 0;
    exp_t exp_q[$];

    // Reference model state: whether an output is presented, whether scanning,
    // and how many cycles have elapsed since scan entry.
    bit m_valid = 1'b0;
    bit m_scan  = 1'b0;
    int m_step  = 0;

    onehot_decoder_seq #(
        .ADDR_W  (ADDR_W),
        .NUM_OUT (NUM_OUT),
        .SCAN_DIV(SCAN_DIV)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .mode     (mode),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_addr  (in_addr),
        .out_ready(out_ready),
        .y        (y),
        .y_valid  (y_valid),
        .addr_err (addr_err),
        .scan_wrap(scan_wrap)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit model_ready();
        return !mode && !m_scan && (!m_valid || out_ready);
    endfunction

    // Advance the reference model across one rising edge.
    task automatic model_edge();
        exp_t e;
        bit   rdy;
        int   idx;
        rdy = model_ready();
        e   = '0;
        if (mode && !m_scan) begin
            m_scan  = 1'b1;
            m_step  = 0;
            m_valid = 1'b1;
            e.y     = NUM_OUT'(1);
            exp_q.push_back(e);
        end else if (mode) begin
            m_step++;
            idx    = (m_step / SCAN_DIV) % NUM_OUT;
            e.y    = NUM_OUT'(1) << idx;
            e.wrap = (m_step % (NUM_OUT * SCAN_DIV)) == 0;
            exp_q.push_back(e);
        end else if (m_scan) begin
            m_scan  = 1'b0;
            m_valid = 1'b0;
        end else if (in_valid && rdy) begin
            m_valid = 1'b1;
            if (in_addr < NUM_OUT) begin
                e.y = NUM_OUT'(1) << in_addr;
            end else begin
                e.err = 1'b1;
            end
            exp_q.push_back(e);
        end else if (m_valid && out_ready) begin
            m_valid = 1'b0;
        end
    endtask

    // Drive one cycle starting 2 time units after an edge.
    task automatic cyc(input logic m, input logic iv, input logic [ADDR_W-1:0] a,
                       input logic ordy);
        mode      = m;
        in_valid  = iv;
        in_addr   = a;
        out_ready = ordy;
        #1;
        chk("in_ready", 64'(in_ready), 64'(model_ready()));
        @(posedge clk);
        model_edge();
        #2;
    endtask

    // Monitor: pops an expectation whenever the DUT presents a new output.
    initial begin
        logic               p_valid;
        logic               p_ordy;
        logic               p_mode;
        logic [NUM_OUT-1:0] last_y;
        exp_t               e;
        p_valid = 1'b0;
        p_ordy  = 1'b0;
        p_mode  = 1'b0;
        last_y  = '0;
        forever begin
            @(negedge clk);
            chk("y_valid", 64'(y_valid), 64'(m_valid));
            if (y_valid) begin
                if (!p_valid || p_ordy || p_mode) begin
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_output: got y=%0h with no expectation queued at %0t",
                                 y, $time);
                    end else begin
                        e = exp_q.pop_front();
                        chk("y", 64'(y), 64'(e.y));
                        chk("addr_err", 64'(addr_err), 64'(e.err));
                        chk("scan_wrap", 64'(scan_wrap), 64'(e.wrap));
                    end
                end else begin
                    chk("hold_y", 64'(y), 64'(last_y));
                    chk("hold_addr_err", 64'(addr_err), 64'(0));
                    chk("hold_scan_wrap", 64'(scan_wrap), 64'(0));
                end
            end else begin
                chk("idle_y", 64'(y), 64'(0));
                chk("idle_addr_err", 64'(addr_err), 64'(0));
                chk("idle_scan_wrap", 64'(scan_wrap), 64'(0));
            end
            last_y  = y;
            p_valid = y_valid;
            p_ordy  = out_ready;
            p_mode  = mode;
        end
    end

    initial begin
        rst       = 1'b1;
        mode      = 1'b0;
        in_valid  = 1'b0;
        in_addr   = '0;
        out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #2;
        chk("rst_y", 64'(y), 64'(0));
        chk("rst_y_valid", 64'(y_valid), 64'(0));
        chk("rst_addr_err", 64'(addr_err), 64'(0));
        chk("rst_scan_wrap", 64'(scan_wrap), 64'(0));
        rst = 1'b0;
        cyc(1'b0, 1'b0, '0, 1'b1);

        // Back-to-back accepts across every in-range address.
        for (int a = 0; a < NUM_OUT; a++) begin
            cyc(1'b0, 1'b1, ADDR_W'(a), 1'b1);
        end
        cyc(1'b0, 1'b0, '0, 1'b1);

        // Backpressure: hold 2 while addr 1 waits.
        cyc(1'b0, 1'b1, 3'd2, 1'b1);
        repeat (3) cyc(1'b0, 1'b1, 3'd1, 1'b0);
        cyc(1'b0, 1'b1, 3'd1, 1'b1);
        repeat (2) cyc(1'b0, 1'b0, '0, 1'b1);

        // Out-of-range addresses then the highest legal one.
        cyc(1'b0, 1'b1, 3'd6, 1'b1);
        cyc(1'b0, 1'b1, 3'd7, 1'b1);
        cyc(1'b0, 1'b1, 3'd5, 1'b1);
        cyc(1'b0, 1'b0, '0, 1'b1);

        // Mode change while holding an unconsumed output.
        cyc(1'b0, 1'b1, 3'd2, 1'b0);
        cyc(1'b0, 1'b0, '0, 1'b0);
        repeat (4) cyc(1'b1, 1'b1, 3'd3, 1'b0);
        repeat (2) cyc(1'b0, 1'b0, '0, 1'b0);
        cyc(1'b0, 1'b0, '0, 1'b1);

        // Two full scan periods with inputs that must be ignored.
        for (int i = 0; i < 2 * NUM_OUT * SCAN_DIV + 4; i++) begin
            cyc(1'b1, 1'($urandom_range(0, 1)), ADDR_W'($urandom_range(0, 7)),
                1'($urandom_range(0, 1)));
        end
        cyc(1'b0, 1'b0, '0, 1'b1);

        // Asynchronous reset between edges mid-scan, then scan restart.
        repeat (8) cyc(1'b1, 1'b0, '0, 1'b1);
        rst = 1'b1;
        #1;
        chk("arst_y", 64'(y), 64'(0));
        chk("arst_y_valid", 64'(y_valid), 64'(0));
        chk("arst_scan_wrap", 64'(scan_wrap), 64'(0));
        m_valid = 1'b0;
        m_scan  = 1'b0;
        exp_q.delete();
        @(posedge clk);
        #2;
        @(posedge clk);
        #2;
        rst = 1'b0;
        repeat (NUM_OUT * SCAN_DIV + 3) cyc(1'b1, 1'b0, '0, 1'b1);
        cyc(1'b0, 1'b0, '0, 1'b1);

        // Randomized traffic with occasional mode flips.
        begin
            logic m;
            m = 1'b0;
            for (int i = 0; i < 600; i++) begin
                if ($urandom_range(0, 15) == 0) m = !m;
                cyc(m, 1'($urandom_range(0, 3) != 0), ADDR_W'($urandom_range(0, 7)),
                    1'($urandom_range(0, 2) != 0));
            end
        end

        repeat (4) cyc(1'b0, 1'b0, '0, 1'b1);
        chk("queue_empty", 64'(exp_q.size()), 64'(0));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
